// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - IRQ/exception sequencer with kernel mode and post-return guard window
module trap_sequencer #(
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
  parameter logic [4:0]  EPC_REG   = 5'd26,
  parameter int          GUARD_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_undef,
  input  logic        id_eret,
  input  logic        id_stall,
  input  logic        ex_redirect,
  output logic        trap_take,
  output logic [31:0] trap_vec,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        epc_we,
  output logic [4:0]  epc_addr,
  output logic [31:0] epc_data,
  output logic        kernel,
  output logic        irq_pend,
  output logic        nested_exc
);

  typedef enum logic [1:0] {
    USER   = 2'd0,
    KERNEL = 2'd1,
    GUARD  = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYC);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       kernel_nx, nested_nx, irq_pend_nx;
  logic       ok, exc_hit, irq_hit, eret_hit;

  assign epc_addr = EPC_REG;

  // Qualify the ID-stage instruction and decide which event (if any) fires this cycle
  always_comb begin
    ok       = id_valid & ~id_stall & ~ex_redirect;
    exc_hit  = ok & id_undef;
    irq_hit  = 1'b0;
    eret_hit = 1'b0;
    case (state)
      USER:    irq_hit  = ok & irq_pend & ~id_undef;
      KERNEL:  eret_hit = ok & id_eret & ~id_undef;
      default: ;
    endcase
  end

  // State register plus mode flags, guard counter and registered IRQ request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= USER;
      cnt        <= 4'd0;
      kernel     <= 1'b0;
      irq_pend   <= 1'b0;
      nested_exc <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      kernel     <= kernel_nx;
      irq_pend   <= irq_pend_nx;
      nested_exc <= nested_nx;
    end
  end

  // Next-state: enter kernel on a trap, leave through the guard window on return
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    kernel_nx   = kernel;
    nested_nx   = nested_exc;
    // A taken IRQ consumes the request; an exception leaves it pending for later
    irq_pend_nx = irq_in & ~irq_hit;
    case (state)
      USER: begin
        if (exc_hit | irq_hit) begin
          state_nx  = KERNEL;
          kernel_nx = 1'b1;
        end
      end
      KERNEL: begin
        if (exc_hit) begin
          nested_nx = 1'b1;
        end else if (eret_hit) begin
          state_nx  = GUARD;
          cnt_nx    = GUARD_INIT;
          kernel_nx = 1'b0;
        end
      end
      GUARD: begin
        if (exc_hit) begin
          state_nx  = KERNEL;
          cnt_nx    = 4'd0;
          kernel_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) state_nx = USER;
        end
      end
      default: state_nx = USER;
    endcase
  end

  // Mealy trap outputs; held inactive while reset is asserted
  always_comb begin
    trap_take  = 1'b0;
    trap_vec   = IRQ_VEC;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    epc_we     = 1'b0;
    epc_data   = 32'd0;
    if (reset) begin
      if (exc_hit) begin
        trap_take  = 1'b1;
        trap_vec   = EXC_VEC;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        // A nested exception must not clobber the EPC of the outer trap
        if (state != KERNEL) begin
          epc_we   = 1'b1;
          epc_data = id_pc + 32'd4;
        end
      end else if (irq_hit) begin
        trap_take  = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        epc_we     = 1'b1;
        epc_data   = id_pc;
      end
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer
module tb_trap_sequencer;

  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;
  localparam int          GCYC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_in, id_valid, id_undef, id_eret, id_stall, ex_redirect;
  logic [31:0] id_pc;
  logic        trap_take, flush_ifid, flush_idex, epc_we, kernel, irq_pend, nested_exc;
  logic [31:0] trap_vec, epc_data;
  logic [4:0]  epc_addr;

  int checks = 0;
  int errors = 0;

  trap_sequencer #(
    .IRQ_VEC(IRQ_V), .EXC_VEC(EXC_V), .EPC_REG(5'd26), .GUARD_CYC(GCYC)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .id_valid(id_valid), .id_pc(id_pc),
    .id_undef(id_undef), .id_eret(id_eret), .id_stall(id_stall), .ex_redirect(ex_redirect),
    .trap_take(trap_take), .trap_vec(trap_vec), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .epc_we(epc_we), .epc_addr(epc_addr), .epc_data(epc_data), .kernel(kernel),
    .irq_pend(irq_pend), .nested_exc(nested_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        irq, valid;
    logic [31:0] pc;
    logic        undef, eret, stall, redir;
    logic        take;
    logic [31:0] vec;
    logic        we;
    logic [31:0] data;
    logic        kern, pend, nest;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic irq, valid, input logic [31:0] pc,
                              input logic undef, eret, stall, redir, take,
                              input logic [31:0] vec, input logic we,
                              input logic [31:0] data, input logic kern, pend, nest);
    vec_t v;
    v.irq = irq; v.valid = valid; v.pc = pc; v.undef = undef; v.eret = eret;
    v.stall = stall; v.redir = redir; v.take = take; v.vec = vec; v.we = we;
    v.data = data; v.kern = kern; v.pend = pend; v.nest = nest;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic irq, valid, input logic [31:0] pc,
                       input logic undef, eret, stall, redir);
    @(negedge clk);
    irq_in = irq; id_valid = valid; id_pc = pc; id_undef = undef;
    id_eret = eret; id_stall = stall; ex_redirect = redir;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic take, input logic [31:0] vec,
                         input logic we, input logic [31:0] data,
                         input logic kern, pend, nest);
    chk({tag, " trap_take"}, 32'(trap_take), 32'(take));
    chk({tag, " trap_vec"}, trap_vec, vec);
    chk({tag, " flush_ifid"}, 32'(flush_ifid), 32'(take));
    chk({tag, " flush_idex"}, 32'(flush_idex), 32'(take));
    chk({tag, " epc_we"}, 32'(epc_we), 32'(we));
    chk({tag, " epc_data"}, epc_data, data);
    chk({tag, " kernel"}, 32'(kernel), 32'(kern));
    chk({tag, " irq_pend"}, 32'(irq_pend), 32'(pend));
    chk({tag, " nested_exc"}, 32'(nested_exc), 32'(nest));
  endtask

  // Reference model state: mode, remaining guard cycles, pending IRQ, nested flag
  bit m_kern, m_pend, m_nest;
  int m_guard;

  initial begin
    // irq valid pc undef eret stall redir | take vec we data kern pend nest
    tbl[0]  = mk(1,1,32'h40,0,0,0,0, 0,IRQ_V,0,32'h0,  0,0,0);
    tbl[1]  = mk(1,1,32'h40,0,0,0,0, 1,IRQ_V,1,32'h40, 0,1,0);
    tbl[2]  = mk(0,1,IRQ_V,0,1,0,0,  0,IRQ_V,0,32'h0,  1,0,0);
    tbl[3]  = mk(1,1,32'h44,0,0,0,0, 0,IRQ_V,0,32'h0,  0,0,0);
    tbl[4]  = mk(1,1,32'h48,0,0,0,0, 0,IRQ_V,0,32'h0,  0,1,0);
    tbl[5]  = mk(1,1,32'h100,1,0,0,0, 1,EXC_V,1,32'h104, 0,1,0);
    tbl[6]  = mk(1,1,32'h80000010,1,0,0,0, 1,EXC_V,0,32'h0, 1,1,0);
    tbl[7]  = mk(1,1,32'h80000014,0,1,0,0, 0,IRQ_V,0,32'h0, 1,1,1);
    tbl[8]  = mk(1,1,32'h104,0,0,0,0, 0,IRQ_V,0,32'h0, 0,1,1);
    tbl[9]  = mk(1,1,32'h104,0,0,0,0, 0,IRQ_V,0,32'h0, 0,1,1);
    tbl[10] = mk(1,1,32'h104,0,0,0,1, 0,IRQ_V,0,32'h0, 0,1,1);
    tbl[11] = mk(1,1,32'h104,0,0,1,0, 0,IRQ_V,0,32'h0, 0,1,1);
    tbl[12] = mk(1,0,32'h104,0,0,0,0, 0,IRQ_V,0,32'h0, 0,1,1);
    tbl[13] = mk(1,1,32'h104,0,0,0,0, 1,IRQ_V,1,32'h104, 0,1,1);
    tbl[14] = mk(0,1,IRQ_V,0,0,0,0,  0,IRQ_V,0,32'h0, 1,0,1);
    tbl[15] = mk(0,1,32'h80000008,0,1,0,0, 0,IRQ_V,0,32'h0, 1,0,1);
    tbl[16] = mk(0,1,32'hFFFFFFFC,1,0,0,0, 1,EXC_V,1,32'h0, 0,0,1);
    tbl[17] = mk(0,0,32'h0,0,0,0,0, 0,IRQ_V,0,32'h0, 1,0,1);

    reset = 1'b0;
    irq_in = 0; id_valid = 0; id_pc = 0; id_undef = 0; id_eret = 0; id_stall = 0; ex_redirect = 0;
    #1;
    chk_all("reset", 0, IRQ_V, 0, 32'h0, 0, 0, 0);
    chk("reset epc_addr", 32'(epc_addr), 32'd26);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].irq, tbl[i].valid, tbl[i].pc, tbl[i].undef, tbl[i].eret,
            tbl[i].stall, tbl[i].redir);
      chk_all($sformatf("vec%0d", i), tbl[i].take, tbl[i].vec, tbl[i].we, tbl[i].data,
              tbl[i].kern, tbl[i].pend, tbl[i].nest);
    end

    // Randomized run against the reference model (starts in kernel, nested set)
    m_kern = 1; m_guard = 0; m_pend = 0; m_nest = 1;
    for (int n = 0; n < 1500; n++) begin
      logic r_irq, r_val, r_und, r_ert, r_stl, r_red, ok;
      logic [31:0] r_pc;
      logic e_take, e_we, irq_taken;
      logic [31:0] e_vec, e_data;
      r_irq = ($urandom_range(0, 2) != 0);
      r_val = ($urandom_range(0, 5) != 0);
      r_und = ($urandom_range(0, 11) == 0);
      r_ert = ($urandom_range(0, 3) == 0);
      r_stl = ($urandom_range(0, 7) == 0);
      r_red = ($urandom_range(0, 7) == 0);
      r_pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive(r_irq, r_val, r_pc, r_und, r_ert, r_stl, r_red);

      ok = r_val && !r_stl && !r_red;
      e_take = 0; e_we = 0; e_vec = IRQ_V; e_data = 0; irq_taken = 0;
      if (m_kern) begin
        if (ok && r_und) begin
          e_take = 1; e_vec = EXC_V;
        end
      end else if (ok && r_und) begin
        e_take = 1; e_vec = EXC_V; e_we = 1; e_data = r_pc + 32'd4;
      end else if (ok && m_pend && m_guard == 0) begin
        e_take = 1; e_we = 1; e_data = r_pc; irq_taken = 1;
      end
      chk_all($sformatf("rnd%0d", n), e_take, e_vec, e_we, e_data, m_kern, m_pend, m_nest);

      // Advance the model one clock
      if (m_kern) begin
        if (ok && r_und) m_nest = 1;
        else if (ok && r_ert) begin m_kern = 0; m_guard = GCYC; end
      end else if (ok && r_und) begin
        m_kern = 1; m_guard = 0;
      end else if (irq_taken) begin
        m_kern = 1;
      end else if (m_guard > 0) begin
        m_guard = m_guard - 1;
      end
      m_pend = r_irq && !irq_taken;
    end

    // Asynchronous reset while in kernel with trap-causing inputs held
    drive(0, 1, 32'h200, 1, 0, 0, 0);
    drive(1, 1, 32'h204, 1, 0, 0, 0);
    chk("pre-reset kernel", 32'(kernel), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 0, IRQ_V, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    irq_in = 0; id_valid = 0; id_undef = 0;
    reset = 1'b1;
    #1;
    chk_all("post_reset", 0, IRQ_V, 0, 32'h0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
